park_meter: RTL and testbench

PARK_METER -- requirements
Module: park_meter

---
 rtl/park_meter_pkg.sv | 28 ++
 rtl/park_meter_clk_div.sv | 28 ++
 rtl/park_meter.sv | 151 +++++++++++++++
 tb/tb_park_meter.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/park_meter_pkg.sv
// Shared types and constants for the parking meter and its display block.
package park_meter_pkg;

  // Meter session states, 2-bit encoding.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PARKED   = 2'd1,
    ST_NEED_PAY = 2'd2,
    ST_DELAY    = 2'd3
  } state_t;

  // Hour counter widths, shared with the segment display block.
  localparam int unsigned DAY_W   = 6;
  localparam int unsigned NIGHT_W = 5;
  localparam int unsigned SUM_W   = 7;

  // Combined day+night hours are capped here so the fee 2*day+night stays <= 126.
  localparam logic [SUM_W-1:0]   MAX_TIME_SUM = 7'd63;
  localparam logic [DAY_W-1:0]   DAY_MAX      = '1;
  localparam logic [NIGHT_W-1:0] NIGHT_MAX    = '1;

  // Total billed hours, widened so the sum never wraps.
  function automatic logic [SUM_W-1:0] time_sum(input logic [DAY_W-1:0]   day,
                                                 input logic [NIGHT_W-1:0] night);
    return SUM_W'(day) + SUM_W'(night);
  endfunction

endpackage

// File: rtl/park_meter_clk_div.sv
// Free-running modulus-DIV prescaler producing a one-cycle pulse on wrap.
module clk_div #(
  parameter int unsigned DIV = 2
) (
  input  logic clk,
  input  logic rst,
  output logic wrap_o
);

  localparam int unsigned  W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign wrap_o = (cnt_q == LAST);

  // Next prescaler value: restart at zero after the last count.
  always_comb begin
    cnt_d = wrap_o ? '0 : cnt_q + W'(1);
  end

  // Prescaler register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/park_meter.sv
// Single-space parking meter: occupancy count, day/night hour billing,
// pay hand-off delay, plus free-running display scan and blink timing.
module park_meter
  import park_meter_pkg::*;
#(
  parameter logic [5:0]  CAPACITY    = 6'd50,
  parameter logic [15:0] SCAN_DIV    = 16'd5000,
  parameter logic [23:0] FLICKER_DIV = 24'd2500000,
  parameter logic [27:0] DELAY_CYC   = 28'd150000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               power,
  input  logic               tick,
  input  logic               is_night,
  input  logic               car_in,
  input  logic               car_out,
  input  logic               pay,
  output logic [5:0]         count,
  output logic [2:0]         scan_cnt,
  output logic               flicker_clk,
  output logic               delay,
  output logic               need_pay,
  output logic [DAY_W-1:0]   time_day,
  output logic [NIGHT_W-1:0] time_night
);

  state_t               state_q, state_d;
  logic [5:0]           count_q, count_d;
  logic [DAY_W-1:0]     day_q, day_d;
  logic [NIGHT_W-1:0]   night_q, night_d;
  logic [27:0]          dly_q, dly_d;
  logic                 need_pay_q, delay_q;
  logic [2:0]           scan_q;
  logic                 flicker_q;
  logic                 scan_wrap, flicker_wrap;
  logic                 time_room;

  assign time_room = time_sum(day_q, night_q) < MAX_TIME_SUM;

  clk_div #(.DIV(32'(SCAN_DIV))) u_scan_div (
    .clk    (clk),
    .rst    (rst),
    .wrap_o (scan_wrap)
  );

  clk_div #(.DIV(32'(FLICKER_DIV))) u_flicker_div (
    .clk    (clk),
    .rst    (rst),
    .wrap_o (flicker_wrap)
  );

  // Next-state and datapath decisions for the meter session.
  always_comb begin
    // NOTE: every signal gets a hold default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    count_d = count_q;
    day_d   = day_q;
    night_d = night_q;
    dly_d   = dly_q;

    if (!power) begin
      state_d = ST_IDLE;
      day_d   = '0;
      night_d = '0;
      dly_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (car_in && count_q != '0) begin
            state_d = ST_PARKED;
            count_d = count_q - 6'd1;
            day_d   = '0;
            night_d = '0;
          end
        end
        ST_PARKED: begin
          // car_out takes priority over a same-cycle tick or car_in.
          if (car_out) begin
            state_d = ST_NEED_PAY;
          end else if (tick && time_room) begin
            if (is_night) begin
              if (night_q != NIGHT_MAX) night_d = night_q + NIGHT_W'(1);
            end else begin
              if (day_q != DAY_MAX) day_d = day_q + DAY_W'(1);
            end
          end
        end
        ST_NEED_PAY: begin
          if (pay) begin
            state_d = ST_DELAY;
            count_d = (count_q < CAPACITY) ? count_q + 6'd1 : CAPACITY;
            dly_d   = DELAY_CYC - 28'd1;
          end
        end
        ST_DELAY: begin
          if (dly_q == '0) begin
            state_d = ST_IDLE;
            day_d   = '0;
            night_d = '0;
          end else begin
            dly_d = dly_q - 28'd1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Session FSM registers with flags decoded from the next state.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses <= so every register samples pre-edge values.
    if (rst) begin
      state_q    <= ST_IDLE;
      count_q    <= CAPACITY;
      day_q      <= '0;
      night_q    <= '0;
      dly_q      <= '0;
      need_pay_q <= 1'b0;
      delay_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      day_q      <= day_d;
      night_q    <= night_d;
      dly_q      <= dly_d;
      need_pay_q <= (state_d == ST_NEED_PAY);
      delay_q    <= (state_d == ST_DELAY);
    end
  end

  // Display timing runs regardless of power.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_q    <= '0;
      flicker_q <= 1'b0;
    end else begin
      if (scan_wrap)    scan_q    <= scan_q + 3'd1;
      if (flicker_wrap) flicker_q <= ~flicker_q;
    end
  end

  assign count       = count_q;
  assign time_day    = day_q;
  assign time_night  = night_q;
  assign need_pay    = need_pay_q;
  assign delay       = delay_q;
  assign scan_cnt    = scan_q;
  assign flicker_clk = flicker_q;

endmodule

// File: tb/tb_park_meter.sv
// Randomised and directed bench for park_meter against a behavioural model.
module tb_park_meter;

  localparam int SCAN_DIV    = 2;
  localparam int FLICKER_DIV = 3;
  localparam int DELAY_CYC   = 10;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic power = 1'b0, tick = 1'b0, is_night = 1'b0;
  logic car_in = 1'b0, car_out = 1'b0, pay = 1'b0;

  logic [5:0] count_a, count_b;
  logic [2:0] scan_a, scan_b;
  logic       flick_a, flick_b, delay_a, delay_b, np_a, np_b;
  logic [5:0] day_a, day_b;
  logic [4:0] night_a, night_b;

  always #5 clk = ~clk;

  park_meter #(.CAPACITY(6'd50), .SCAN_DIV(16'd2), .FLICKER_DIV(24'd3), .DELAY_CYC(28'd10)) dut_a (
    .clk(clk), .rst(rst), .power(power), .tick(tick), .is_night(is_night),
    .car_in(car_in), .car_out(car_out), .pay(pay),
    .count(count_a), .scan_cnt(scan_a), .flicker_clk(flick_a), .delay(delay_a),
    .need_pay(np_a), .time_day(day_a), .time_night(night_a)
  );

  park_meter #(.CAPACITY(6'd1), .SCAN_DIV(16'd2), .FLICKER_DIV(24'd3), .DELAY_CYC(28'd10)) dut_b (
    .clk(clk), .rst(rst), .power(power), .tick(tick), .is_night(is_night),
    .car_in(car_in), .car_out(car_out), .pay(pay),
    .count(count_b), .scan_cnt(scan_b), .flicker_clk(flick_b), .delay(delay_b),
    .need_pay(np_b), .time_day(day_b), .time_night(night_b)
  );

  // Behavioural model of one meter.
  typedef enum {M_IDLE, M_PARK, M_OWE, M_WAIT} mphase_t;
  typedef struct {
    mphase_t ph;
    int      cap;
    int      free;
    int      day;
    int      night;
    int      wait_left;
  } mstate_t;

  mstate_t ma, mb;
  int      edges   = 0;
  int      n_total = 0;
  int      n_bad   = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_total++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic mstate_t model_reset(input int cap);
    mstate_t r;
    r.ph = M_IDLE; r.cap = cap; r.free = cap;
    r.day = 0; r.night = 0; r.wait_left = 0;
    return r;
  endfunction

  function automatic mstate_t advance(input mstate_t s, input bit pw, input bit tk,
                                      input bit nt, input bit ci, input bit co, input bit py);
    mstate_t r;
    r = s;
    if (!pw) begin
      r.ph = M_IDLE; r.day = 0; r.night = 0; r.wait_left = 0;
      return r;
    end
    case (s.ph)
      M_IDLE: if (ci && s.free > 0) begin
        r.ph = M_PARK; r.free = s.free - 1; r.day = 0; r.night = 0;
      end
      M_PARK: begin
        if (co) r.ph = M_OWE;
        else if (tk && s.day + s.night < 63) begin
          if (nt) begin
            if (s.night < 31) r.night = s.night + 1;
          end else if (s.day < 63) r.day = s.day + 1;
        end
      end
      M_OWE: if (py) begin
        r.ph = M_WAIT;
        r.free = (s.free < s.cap) ? s.free + 1 : s.cap;
        r.wait_left = DELAY_CYC;
      end
      M_WAIT: begin
        r.wait_left = s.wait_left - 1;
        if (r.wait_left == 0) begin
          r.ph = M_IDLE; r.day = 0; r.night = 0;
        end
      end
      default: r.ph = M_IDLE;
    endcase
    return r;
  endfunction

  task automatic compare_all();
    check("a_count",   int'(count_a), ma.free);
    check("a_day",     int'(day_a),   ma.day);
    check("a_night",   int'(night_a), ma.night);
    check("a_needpay", int'(np_a),    int'(ma.ph == M_OWE));
    check("a_delay",   int'(delay_a), int'(ma.ph == M_WAIT));
    check("a_scan",    int'(scan_a),  (edges / SCAN_DIV) % 8);
    check("a_flicker", int'(flick_a), (edges / FLICKER_DIV) % 2);
    check("b_count",   int'(count_b), mb.free);
    check("b_day",     int'(day_b),   mb.day);
    check("b_night",   int'(night_b), mb.night);
    check("b_needpay", int'(np_b),    int'(mb.ph == M_OWE));
    check("b_delay",   int'(delay_b), int'(mb.ph == M_WAIT));
  endtask

  // Apply one cycle of inputs, advance the models on the edge, compare after it.
  task automatic cycle(input bit pw, input bit tk, input bit nt,
                       input bit ci, input bit co, input bit py);
    power = pw; tick = tk; is_night = nt; car_in = ci; car_out = co; pay = py;
    @(posedge clk);
    ma = advance(ma, pw, tk, nt, ci, co, py);
    mb = advance(mb, pw, tk, nt, ci, co, py);
    edges++;
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1, 0, 0, 0, 0, 0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_count"},   int'(count_a), 50);
    check({tag, "_day"},     int'(day_a),   0);
    check({tag, "_night"},   int'(night_a), 0);
    check({tag, "_needpay"}, int'(np_a),    0);
    check({tag, "_delay"},   int'(delay_a), 0);
    check({tag, "_scan"},    int'(scan_a),  0);
    check({tag, "_flicker"}, int'(flick_a), 0);
    check({tag, "_bcount"},  int'(count_b), 1);
  endtask

  task automatic release_reset();
    ma = model_reset(50);
    mb = model_reset(1);
    edges = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    #1 rst = 1'b1;
    #2 check_reset_values("rst0");
    repeat (2) @(posedge clk);
    release_reset();

    // Basic session: park, bill 3 day and 2 night hours.
    cycle(1, 0, 0, 1, 0, 0);
    check("s1_count", int'(count_a), 49);
    for (int i = 0; i < 3; i++) cycle(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) cycle(1, 1, 1, 0, 0, 0);
    check("s1_day", int'(day_a), 3);
    check("s1_night", int'(night_a), 2);

    // car_out together with tick and car_in: leave wins, tick dropped.
    cycle(1, 1, 0, 1, 1, 0);
    check("s2_needpay", int'(np_a), 1);
    for (int i = 0; i < 4; i++) cycle(1, 1, i[0], 0, 0, 0);
    check("s2_day_held", int'(day_a), 3);
    check("s2_night_held", int'(night_a), 2);

    // Pay, then exactly DELAY_CYC cycles in DELAY.
    cycle(1, 0, 0, 0, 0, 1);
    check("s3_delay", int'(delay_a), 1);
    check("s3_needpay", int'(np_a), 0);
    check("s3_count", int'(count_a), 50);
    idle(DELAY_CYC - 1);
    check("s3_delay_last", int'(delay_a), 1);
    check("s3_day_shown", int'(day_a), 3);
    idle(1);
    check("s3_delay_off", int'(delay_a), 0);
    check("s3_day_clr", int'(day_a), 0);
    check("s3_night_clr", int'(night_a), 0);

    // Saturation: 5 night hours then day ticks stop at 58.
    cycle(1, 0, 0, 1, 0, 0);
    for (int i = 0; i < 5; i++) cycle(1, 1, 1, 0, 0, 0);
    for (int i = 0; i < 70; i++) cycle(1, 1, 0, 0, 0, 0);
    check("s4_day58", int'(day_a), 58);
    check("s4_night5", int'(night_a), 5);
    cycle(1, 0, 0, 0, 1, 0);
    cycle(1, 0, 0, 0, 0, 1);
    idle(DELAY_CYC);
    cycle(1, 0, 0, 1, 0, 0);
    for (int i = 0; i < 70; i++) cycle(1, 1, 0, 0, 0, 0);
    check("s4_day63", int'(day_a), 63);
    for (int i = 0; i < 3; i++) cycle(1, 1, 1, 0, 0, 0);
    check("s4_night_blocked", int'(night_a), 0);
    cycle(1, 0, 0, 0, 1, 0);
    cycle(1, 0, 0, 0, 0, 1);
    idle(DELAY_CYC);

    // Single-space meter: second car with no space is refused.
    cycle(1, 0, 0, 1, 0, 0);
    check("s5_b_count0", int'(count_b), 0);
    cycle(1, 0, 0, 0, 1, 0);
    cycle(0, 0, 0, 0, 0, 0);
    check("s5_b_idle", int'(np_b), 0);
    check("s5_a_count_hold", int'(count_a), 49);
    cycle(1, 0, 0, 1, 0, 0);
    check("s5_b_refused", int'(count_b), 0);
    cycle(1, 0, 0, 0, 1, 0);
    check("s5_b_not_owing", int'(np_b), 0);
    check("s5_a_owing", int'(np_a), 1);
    cycle(0, 0, 0, 0, 0, 0);

    // Reset asserted mid-DELAY takes effect without a clock edge.
    cycle(1, 0, 0, 1, 0, 0);
    cycle(1, 0, 0, 0, 1, 0);
    cycle(1, 0, 0, 0, 0, 1);
    idle(3);
    check("s6_in_delay", int'(delay_a), 1);
    #2 rst = 1'b1;
    #1 check_reset_values("s6_async");
    release_reset();
    for (int i = 0; i < 16; i++) begin
      cycle(1, 0, 0, 0, 0, 0);
      if (edges == 14) check("s6_scan7", int'(scan_a), 7);
      if (edges == 16) check("s6_scan_wrap", int'(scan_a), 0);
    end

    // Random traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      cycle($urandom_range(0, 99) < 97, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
            $urandom_range(0, 99) < 25, $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 25);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
